// File: rtl/counter_12_wrap_mon.sv
// Wrap monitor for the mod-12 counter: counts MOD-1 -> 0 wraps, queues events, flags bad values.
// Optional STEP_CHECK_EN macro adds illegal-step and moved-while-disabled checks to range_err.
module counter_12_wrap_mon #(
    parameter int MOD       = 12,
    parameter int WRAP_W    = 8,
    parameter int EVT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              cnt_valid,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WRAP_W-1:0] evt_data,
    output logic              evt_ovf,
    output logic              range_err,
    input  logic              clr_err
);

    localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam logic [3:0]        CNT_MAX = 4'(MOD - 1);
    localparam logic [3:0]        ONE_C   = 4'd1;
    localparam logic [AW-1:0]     ONE_P   = AW'(1);
    localparam logic [AW:0]       ONE_O   = (AW + 1)'(1);
    localparam logic [AW:0]       DEPTH_O = (AW + 1)'(EVT_DEPTH);
    localparam logic [WRAP_W-1:0] ONE_W   = WRAP_W'(1);

    logic [3:0]        prev_cnt_q, prev_cnt_d;
    logic              prev_en_q, prev_en_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] mem_q [EVT_DEPTH];
    logic [WRAP_W-1:0] mem_d [EVT_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       occ_q, occ_d;
    logic              evt_ovf_q, evt_ovf_d;
    logic              range_err_q, range_err_d;

    logic              det;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              range_set;
    logic [WRAP_W-1:0] wrap_nxt;

`ifdef STEP_CHECK_EN
    logic [3:0] step_nxt;
`else
    logic       unused_en;
    assign unused_en = prev_en_q;
`endif

    always_comb begin
        det       = (prev_cnt_q == CNT_MAX) && (cnt_in == '0);
        empty     = (occ_q == '0);
        full      = (occ_q == DEPTH_O);
        pop       = !empty && evt_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
        push      = det && (!full || pop);
        wrap_nxt  = wrap_cnt_q + ONE_W;
        range_set = (cnt_in > CNT_MAX);
`ifdef STEP_CHECK_EN
        step_nxt  = (prev_cnt_q == CNT_MAX) ? 4'd0 : prev_cnt_q + ONE_C;
        if ((cnt_in != prev_cnt_q) && (!prev_en_q || (cnt_in != step_nxt)))
            range_set = 1'b1;
`endif

        prev_cnt_d   = cnt_in;
        prev_en_d    = cnt_valid;
        wrap_cnt_d   = det ? wrap_nxt : wrap_cnt_q;
        wrap_pulse_d = det;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;

        if (push) begin
            mem_d[wr_ptr_q] = wrap_nxt;
            wr_ptr_d        = wr_ptr_q + ONE_P;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + ONE_P;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + ONE_O;
            2'b01:   occ_d = occ_q - ONE_O;
            default: occ_d = occ_q;
        endcase

        evt_ovf_d   = (det && full && !pop) || (evt_ovf_q && !clr_err);
        range_err_d = range_set || (range_err_q && !clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cnt_q   <= '0;
            prev_en_q    <= 1'b0;
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
            for (int i = 0; i < EVT_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            evt_ovf_q    <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            prev_cnt_q   <= prev_cnt_d;
            prev_en_q    <= prev_en_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            evt_ovf_q    <= evt_ovf_d;
            range_err_q  <= range_err_d;
        end
    end

    assign wrap_cnt   = wrap_cnt_q;
    assign wrap_pulse = wrap_pulse_q;
    assign evt_valid  = !empty;
    assign evt_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign evt_ovf    = evt_ovf_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_counter_12_wrap_mon.sv
// Scoreboard bench for counter_12_wrap_mon: directed counter sequences, queued expected events.
// Expected range_err results follow STEP_CHECK_EN when the macro is defined for the build.
module tb_counter_12_wrap_mon;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic [7:0] wrap_cnt;
    logic       wrap_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_data;
    logic       evt_ovf;
    logic       range_err;
    logic       clr_err;

`ifdef STEP_CHECK_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_pulse[$];
    int exp_evt[$];

    counter_12_wrap_mon #(.MOD(12), .WRAP_W(8), .EVT_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .wrap_cnt   (wrap_cnt),
        .wrap_pulse (wrap_pulse),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_ovf    (evt_ovf),
        .range_err  (range_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v);
        cnt_in = 4'(v);
        cyc();
    endtask

    // Run the counter 1..11 then back to 0; w is the wrap count the 0 produces.
    task automatic wrap(input int w, input bit rdy);
        for (int v = 1; v <= 11; v++)
            put(v);
        evt_ready = rdy;
        exp_pulse.push_back(w);
        put(0);
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int i = 0; i < 10 && evt_valid; i++)
            cyc();
        chk("drain_empty", int'(evt_valid), 0);
        chk("drain_queue_left", exp_evt.size(), 0);
        evt_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wrap_pulse) begin
                if (exp_pulse.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got wrap_cnt %0d, expected no pulse",
                             wrap_cnt);
                end else begin
                    chk("pulse_wrap_cnt", int'(wrap_cnt), exp_pulse.pop_front());
                end
            end
            if (evt_valid && evt_ready) begin
                if (exp_evt.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got evt_data %0d, expected none",
                             evt_data);
                end else begin
                    chk("evt_data_pop", int'(evt_data), exp_evt.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        cnt_in    = 4'd0;
        cnt_valid = 1'b1;
        evt_ready = 1'b0;
        clr_err   = 1'b0;

        // T1 reset and idle at zero
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wrap_cnt", int'(wrap_cnt), 0);
        chk("rst_wrap_pulse", int'(wrap_pulse), 0);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_data", int'(evt_data), 0);
        chk("rst_evt_ovf", int'(evt_ovf), 0);
        chk("rst_range_err", int'(range_err), 0);
        rst = 1'b0;
        repeat (15) cyc();
        chk("t1_wrap_cnt", int'(wrap_cnt), 0);
        chk("t1_evt_valid", int'(evt_valid), 0);

        // T2 single wrap, with a pause at 11
        for (int v = 1; v <= 11; v++)
            put(v);
        put(11);
        put(11);
        exp_pulse.push_back(1);
        put(0);
        chk("t2_wrap_pulse", int'(wrap_pulse), 1);
        chk("t2_wrap_cnt", int'(wrap_cnt), 1);
        chk("t2_evt_valid", int'(evt_valid), 1);
        chk("t2_evt_data", int'(evt_data), 1);
        cyc();
        chk("t2_pulse_one_cycle", int'(wrap_pulse), 0);
        chk("t2_evt_data_stable", int'(evt_data), 1);

        // Reset mid-operation drops the queued event at once
        rst = 1'b1;
        #1;
        chk("midrst_evt_valid", int'(evt_valid), 0);
        chk("midrst_wrap_cnt", int'(wrap_cnt), 0);
        chk("midrst_evt_data", int'(evt_data), 0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        // T3 fill and overflow
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4)
                exp_evt.push_back(w);
            wrap(w, 1'b0);
        end
        chk("t3_wrap_cnt", int'(wrap_cnt), 5);
        chk("t3_evt_ovf", int'(evt_ovf), 1);
        chk("t3_evt_valid", int'(evt_valid), 1);
        chk("t3_evt_head", int'(evt_data), 1);
        drain();

        // T4 full FIFO with a pop in the wrap cycle
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("t4_ovf_cleared", int'(evt_ovf), 0);
        for (int w = 6; w <= 9; w++) begin
            exp_evt.push_back(w);
            wrap(w, 1'b0);
        end
        chk("t4_full_no_ovf", int'(evt_ovf), 0);
        exp_evt.push_back(10);
        wrap(10, 1'b1);
        chk("t4_evt_ovf", int'(evt_ovf), 0);
        drain();
        chk("t4_wrap_cnt", int'(wrap_cnt), 10);

        // T5 range error, stickiness, set-wins-over-clear
        put(13);
        chk("t5_range_set", int'(range_err), 1);
        put(0);
        put(0);
        chk("t5_range_hold", int'(range_err), 1);
        clr_err = 1'b1;
        put(14);
        chk("t5_set_wins", int'(range_err), 1);
        clr_err = 1'b0;
        put(0);
        put(0);
        clr_err = 1'b1;
        put(0);
        clr_err = 1'b0;
        chk("t5_range_clear", int'(range_err), 0);
        chk("t5_no_false_wrap", int'(wrap_cnt), 10);

        // T6 step checks
        put(1);
        put(2);
        cnt_valid = 1'b0;
        put(3);
        cnt_valid = 1'b1;
        put(4);
        chk("t6_move_disabled", int'(range_err), STEP);
        put(3);
        put(3);
        clr_err = 1'b1;
        put(3);
        clr_err = 1'b0;
        chk("t6_clear", int'(range_err), 0);
        put(5);
        chk("t6_illegal_step", int'(range_err), STEP);

        repeat (3) cyc();
        chk("pulse_queue_left", exp_pulse.size(), 0);
        chk("evt_queue_left", exp_evt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
